// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word width, RAM handshake states, and the
// arbiter's state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    localparam int ARB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/arb_watchdog.sv
// Cycle counter for a RAM access in progress. Cleared while the arbiter is
// idle, counts each serving cycle that did not complete, and flags the last
// permitted cycle so the arbiter can abort instead of waiting forever.
module arb_watchdog #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Counter: clear has priority over enable so a fresh grant always starts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the icache and dcache.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no grant; arbitrate (dcache first unless icache is owed a turn)
//   SERVE_I | icache read driven onto RAM until ACCESS, drop or timeout
//   SERVE_D | dcache read/write driven onto RAM until ACCESS, drop or timeout
//
// Waits and loads decode from state and ramstate; RAM strobes decode only from
// state and the cache request lines, so ramstate never reaches the strobes.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        bus_err
);

    arb_state_t state, next_state;
    logic       last_d, last_d_next;
    logic       abort;
    logic       dreq;
    logic       access;
    logic       expired;

    assign dreq   = dREN | dWEN;
    assign access = (ramstate == ACCESS);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk     (CLK),
        .rst     (RST),
        .clear   (state == IDLE),
        .enable  ((state != IDLE) && !access),
        .expired (expired)
    );

    // State, fairness flag and sticky abort flag registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state  <= next_state;
            last_d <= last_d_next;
            if (abort) begin
                bus_err <= 1'b1;
            end
        end
    end

    // Next-state: a dropped request beats completion, completion beats timeout.
    always_comb begin
        next_state  = state;
        last_d_next = last_d;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (dreq && !(iREN && last_d)) begin
                    next_state = SERVE_D;
                end else if (iREN) begin
                    next_state = SERVE_I;
                end
            end
            SERVE_I: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else if (access) begin
                    next_state  = IDLE;
                    last_d_next = 1'b0;
                end else if (expired) begin
                    next_state = IDLE;
                    abort      = 1'b1;
                end
            end
            SERVE_D: begin
                if (!dreq) begin
                    next_state = IDLE;
                end else if (access) begin
                    next_state  = IDLE;
                    last_d_next = 1'b1;
                end else if (expired) begin
                    next_state = IDLE;
                    abort      = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode: RAM strobes/address from the granted cache, wait/load pulse on ACCESS.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            SERVE_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (iREN && access) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            SERVE_D: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = dREN;
                end
                if (dreq && access) begin
                    dwait = 1'b0;
                    if (!dWEN) begin
                        dload = ramload;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scripted cycle table, hand-written timeout sequence,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int TIMEOUT = 16;
    localparam logic [31:0] IA = 32'h0000_0040;
    localparam logic [31:0] DA = 32'h0000_0100;
    localparam logic [31:0] DS = 32'hDEAD_BEEF;
    localparam logic [31:0] RL = 32'h8C22_0004;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, bus_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ir, dr, dw;
        logic [1:0]  rs;
        logic        e_iw, e_dw, e_ren, e_wen;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic ir, input logic dr, input logic dw,
                       input logic [1:0] rs, input logic e_iw, input logic e_dw,
                       input logic e_ren, input logic e_wen, input logic [31:0] e_addr);
        vec_t v;
        v.rst = rst; v.ir = ir; v.dr = dr; v.dw = dw; v.rs = rs;
        v.e_iw = e_iw; v.e_dw = e_dw; v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        repeat (2) @(posedge CLK);
    endtask

    // Reference model state: who owns the RAM, cycles spent without completion,
    // whether the dcache was the last cache to complete, and the sticky error.
    int owner;       // 0 none, 1 icache, 2 dcache
    int served;
    bit m_last_d;
    bit m_err;

    initial begin
        int ren_cnt, budget;
        bit saw_dwait, saw_err;
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = IA; daddr = DA; dstore = DS; ramload = RL; ramstate = FREE;

        // ---- table of cycle scripts ----
        // icache read, ACCESS on first serve cycle
        add(0, 1,0,0, FREE,   1,1,0,0, 0);
        add(0, 1,0,0, ACCESS, 0,1,1,0, IA);
        add(0, 0,0,0, FREE,   1,1,0,0, 0);
        // dcache write, 3 BUSY then ACCESS
        add(0, 0,0,1, FREE,   1,1,0,0, 0);
        add(0, 0,0,1, BUSY,   1,1,0,1, DA);
        add(0, 0,0,1, BUSY,   1,1,0,1, DA);
        add(0, 0,0,1, BUSY,   1,1,0,1, DA);
        add(0, 0,0,1, ACCESS, 1,0,0,1, DA);
        add(0, 0,0,0, FREE,   1,1,0,0, 0);
        // reset clears fairness; both request: D, I, D
        add(1, 0,0,0, FREE,   1,1,0,0, 0);
        add(0, 1,1,0, FREE,   1,1,0,0, 0);
        add(0, 1,1,0, BUSY,   1,1,1,0, DA);
        add(0, 1,1,0, ACCESS, 1,0,1,0, DA);
        add(0, 1,1,0, FREE,   1,1,0,0, 0);
        add(0, 1,1,0, ACCESS, 0,1,1,0, IA);
        add(0, 1,1,0, FREE,   1,1,0,0, 0);
        add(0, 1,1,0, ACCESS, 1,0,1,0, DA);
        // no preemption; ERROR behaves as BUSY
        add(0, 0,1,0, FREE,   1,1,0,0, 0);
        add(0, 1,1,0, BUSY,   1,1,1,0, DA);
        add(0, 1,1,0, ERROR,  1,1,1,0, DA);
        add(0, 1,1,0, ACCESS, 1,0,1,0, DA);
        // reset during SERVE_I with BUSY
        add(0, 1,0,0, FREE,   1,1,0,0, 0);
        add(0, 1,0,0, BUSY,   1,1,1,0, IA);
        add(1, 1,0,0, BUSY,   1,1,1,0, IA);
        add(0, 0,0,0, BUSY,   1,1,0,0, 0);
        // dREN dropped after 2 BUSY cycles
        add(0, 0,1,0, FREE,   1,1,0,0, 0);
        add(0, 0,1,0, BUSY,   1,1,1,0, DA);
        add(0, 0,1,0, BUSY,   1,1,1,0, DA);
        add(0, 0,0,0, BUSY,   1,1,0,0, DA);
        add(0, 0,0,0, FREE,   1,1,0,0, 0);
        // fairness untouched by the drop: dcache still wins
        add(0, 1,1,0, FREE,   1,1,0,0, 0);
        add(0, 1,1,0, ACCESS, 1,0,1,0, DA);
        add(0, 0,0,0, FREE,   1,1,0,0, 0);

        do_reset();
        @(negedge CLK); #1;
        check("reset iwait",   32'(iwait),   32'd1);
        check("reset dwait",   32'(dwait),   32'd1);
        check("reset iload",   iload,        32'd0);
        check("reset dload",   dload,        32'd0);
        check("reset ramREN",  32'(ramREN),  32'd0);
        check("reset ramWEN",  32'(ramWEN),  32'd0);
        check("reset ramaddr", ramaddr,      32'd0);
        check("reset ramstore",ramstore,     32'd0);
        check("reset bus_err", 32'(bus_err), 32'd0);

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge CLK);
            RST = tbl[k].rst; iREN = tbl[k].ir; dREN = tbl[k].dr; dWEN = tbl[k].dw;
            ramstate = tbl[k].rs;
            #1;
            check($sformatf("row%0d iwait", k),   32'(iwait),  32'(tbl[k].e_iw));
            check($sformatf("row%0d dwait", k),   32'(dwait),  32'(tbl[k].e_dw));
            check($sformatf("row%0d ramREN", k),  32'(ramREN), 32'(tbl[k].e_ren));
            check($sformatf("row%0d ramWEN", k),  32'(ramWEN), 32'(tbl[k].e_wen));
            check($sformatf("row%0d ramaddr", k), ramaddr,     tbl[k].e_addr);
            check($sformatf("row%0d ramstore", k), ramstore,   tbl[k].e_wen ? DS : 32'd0);
            check($sformatf("row%0d iload", k),   iload,       tbl[k].e_iw ? 32'd0 : RL);
            check($sformatf("row%0d dload", k),   dload,
                  (!tbl[k].e_dw && !tbl[k].dw) ? RL : 32'd0);
            check($sformatf("row%0d bus_err", k), 32'(bus_err), 32'd0);
        end

        // ---- watchdog abort with ramstate stuck BUSY ----
        do_reset();
        @(negedge CLK);
        RST = 1'b0; dWEN = 1'b1; ramstate = BUSY;
        ren_cnt = 0; saw_dwait = 0; saw_err = 0; budget = 0;
        while (!saw_err && budget < 40) begin
            #1;
            if (bus_err) begin
                saw_err = 1;
                check("abort strobe released", 32'(ramWEN), 32'd0);
            end else begin
                if (ramWEN) ren_cnt++;
                if (!dwait) saw_dwait = 1;
                @(negedge CLK);
                budget++;
            end
        end
        check("abort seen within budget", 32'(saw_err), 32'd1);
        check("serve cycles before abort", 32'(ren_cnt), 32'(TIMEOUT));
        check("no dwait pulse on abort", 32'(saw_dwait), 32'd0);
        dWEN = 1'b0; ramstate = FREE;
        repeat (5) @(negedge CLK);
        #1;
        check("bus_err sticky", 32'(bus_err), 32'd1);
        check("dwait idle after abort", 32'(dwait), 32'd1);
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); #1;
        check("bus_err cleared by RST", 32'(bus_err), 32'd0);

        // ---- randomized traffic vs reference model ----
        do_reset();
        owner = 0; served = 0; m_last_d = 0; m_err = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        e_iw, e_dw, e_ren, e_wen;
            logic [31:0] e_il, e_dl, e_addr, e_st;
            int          nxt;
            bit          no_access_mode;
            @(negedge CLK);
            no_access_mode = ((c / 80) % 3) == 2;
            RST = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) iREN = ~iREN;
            if ($urandom_range(0, 15) == 0) dREN = ~dREN;
            if ($urandom_range(0, 23) == 0) dWEN = ~dWEN;
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            if (!no_access_mode && $urandom_range(0, 2) == 0) ramstate = ACCESS;
            else begin
                case ($urandom_range(0, 2))
                    0: ramstate = FREE;
                    1: ramstate = BUSY;
                    default: ramstate = ERROR;
                endcase
            end

            e_iw = 1; e_dw = 1; e_il = 0; e_dl = 0;
            e_ren = 0; e_wen = 0; e_addr = 0; e_st = 0;
            nxt = owner;
            if (owner == 0) begin
                if ((dREN || dWEN) && !(iREN && m_last_d)) nxt = 2;
                else if (iREN) nxt = 1;
                served = 0;
            end else if (owner == 1) begin
                e_ren = iREN; e_addr = iaddr;
                if (!iREN) nxt = 0;
                else if (ramstate == ACCESS) begin
                    e_iw = 0; e_il = ramload; m_last_d = 0; nxt = 0;
                end else if (served == TIMEOUT - 1) begin
                    m_err = 1; nxt = 0;
                end else served++;
            end else begin
                e_addr = daddr;
                e_wen = dWEN; e_ren = dREN && !dWEN; e_st = dWEN ? dstore : 32'd0;
                if (!(dREN || dWEN)) nxt = 0;
                else if (ramstate == ACCESS) begin
                    e_dw = 0; e_dl = dWEN ? 32'd0 : ramload; m_last_d = 1; nxt = 0;
                end else if (served == TIMEOUT - 1) begin
                    m_err = 1; nxt = 0;
                end else served++;
            end

            #1;
            check("rand iwait",   32'(iwait),  32'(e_iw));
            check("rand dwait",   32'(dwait),  32'(e_dw));
            check("rand iload",   iload,       e_il);
            check("rand dload",   dload,       e_dl);
            check("rand ramREN",  32'(ramREN), 32'(e_ren));
            check("rand ramWEN",  32'(ramWEN), 32'(e_wen));
            check("rand ramaddr", ramaddr,     e_addr);
            check("rand ramstore", ramstore,   e_st);

            // bus_err is registered: it shows the error recorded before this cycle.
            owner = nxt;
            if (RST) begin
                owner = 0; served = 0; m_last_d = 0; m_err = 0;
            end
            @(posedge CLK); #1;
            check("rand bus_err", 32'(bus_err), 32'(m_err));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
